// File: rtl/game_pkg.sv
// Shared game-flow definitions: state encoding and per-event line clamp.
// Also used by the overlay and drop-timer blocks.
package game_pkg;

  typedef enum logic [1:0] {
    StReady = 2'd0,
    StPlay  = 2'd1,
    StPause = 2'd2,
    StOver  = 2'd3
  } game_state_e;

  localparam int unsigned MAX_LINES_EVT = 4;

  function automatic logic [2:0] clamp_lines(input logic [2:0] n);
    return (n > 3'(MAX_LINES_EVT)) ? 3'(MAX_LINES_EVT) : n;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Button/board/overlay signal bundle around the game-flow controller.
interface game_flow_ctrl_if #(
  parameter int unsigned LEVEL_W = 4,
  parameter int unsigned LINES_W = 16
);
  logic               start_pulse;
  logic               pause_pulse;
  logic               game_over;
  logic               lines_vld;
  logic [2:0]         lines_n;
  logic               ingame_sig;
  logic               paused;
  logic               over_sig;
  logic               new_game;
  logic [LEVEL_W-1:0] level;
  logic [LINES_W-1:0] lines_total;

  modport slave (
    input  start_pulse, pause_pulse, game_over, lines_vld, lines_n,
    output ingame_sig, paused, over_sig, new_game, level, lines_total
  );

  modport master (
    output start_pulse, pause_pulse, game_over, lines_vld, lines_n,
    input  ingame_sig, paused, over_sig, new_game, level, lines_total
  );
endinterface

// File: rtl/game_score_counter.sv
// Per-game line total and level tracker; lines_total saturates, level caps at MAX_LEVEL.
module game_score_counter
  import game_pkg::*;
#(
  parameter int unsigned LEVEL_W         = 4,
  parameter int unsigned MAX_LEVEL       = 9,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned LINES_W         = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               add_vld_i,
  input  logic [2:0]         lines_n_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic [LINES_W-1:0] lines_total_o
);

  localparam int unsigned SUB_W = 8;

  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LINES_W-1:0] total_q, total_d;
  logic [2:0]         n;
  logic [SUB_W:0]     sub_sum;
  logic [LINES_W:0]   total_sum;

  always_comb begin
    n         = clamp_lines(lines_n_i);
    sub_sum   = {1'b0, sub_q} + (SUB_W+1)'(n);
    total_sum = {1'b0, total_q} + (LINES_W+1)'(n);
    sub_d     = sub_q;
    level_d   = level_q;
    total_d   = total_q;
    if (clear_i) begin
      sub_d   = '0;
      level_d = '0;
      total_d = '0;
    end else if (add_vld_i) begin
      total_d = total_sum[LINES_W] ? '1 : total_sum[LINES_W-1:0];
      // n <= 4 < LINES_PER_LEVEL, so one subtraction always lands back in range
      if (sub_sum >= (SUB_W+1)'(LINES_PER_LEVEL)) begin
        sub_d = SUB_W'(sub_sum - (SUB_W+1)'(LINES_PER_LEVEL));
        if (level_q < LEVEL_W'(MAX_LEVEL)) begin
          level_d = level_q + LEVEL_W'(1);
        end
      end else begin
        sub_d = sub_sum[SUB_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q   <= '0;
      level_q <= '0;
      total_q <= '0;
    end else begin
      sub_q   <= sub_d;
      level_q <= level_d;
      total_q <= total_d;
    end
  end

  assign level_o       = level_q;
  assign lines_total_o = total_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game flow: READY/PLAY/PAUSE/OVER FSM, timed game-over hold, score counter.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LEVEL_W         = 4,
  parameter int unsigned MAX_LEVEL       = 9,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned LINES_W         = 16,
  parameter int unsigned OVER_HOLD       = 50_000_000
) (
  input logic              clk,
  input logic              rst_n,
  game_flow_ctrl_if.slave  bus
);

  localparam int unsigned        HOLD_W    = $clog2(OVER_HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(OVER_HOLD - 1);

  game_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ingame_q, paused_q, over_q, new_game_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      StReady: begin
        if (bus.start_pulse) state_d = StPlay;
      end
      StPlay: begin
        if (bus.game_over) begin
          state_d = StOver;
          hold_d  = '0;
        end else if (bus.pause_pulse) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (bus.start_pulse || bus.pause_pulse) state_d = StPlay;
      end
      StOver: begin
        if (bus.start_pulse || (hold_q == HOLD_LAST)) begin
          state_d = StReady;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = StReady;
    endcase
  end

  // Status flags are registered from state_d so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StReady;
      hold_q     <= '0;
      ingame_q   <= 1'b0;
      paused_q   <= 1'b0;
      over_q     <= 1'b0;
      new_game_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      ingame_q   <= (state_d == StPlay);
      paused_q   <= (state_d == StPause);
      over_q     <= (state_d == StOver);
      new_game_q <= (state_q == StReady) && (state_d == StPlay);
    end
  end

  logic clear;
  logic add_vld;

  assign clear   = (state_q == StReady) && bus.start_pulse;
  assign add_vld = (state_q == StPlay) && bus.lines_vld;

  game_score_counter #(
    .LEVEL_W        (LEVEL_W),
    .MAX_LEVEL      (MAX_LEVEL),
    .LINES_PER_LEVEL(LINES_PER_LEVEL),
    .LINES_W        (LINES_W)
  ) u_score (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear),
    .add_vld_i    (add_vld),
    .lines_n_i    (bus.lines_n),
    .level_o      (bus.level),
    .lines_total_o(bus.lines_total)
  );

  assign bus.ingame_sig = ingame_q;
  assign bus.paused     = paused_q;
  assign bus.over_sig   = over_q;
  assign bus.new_game   = new_game_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with OVER_HOLD=8, MAX_LEVEL=2, LINES_W=4.
module tb_game_flow_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   n_fail;
  int   cnt;

  game_flow_ctrl_if #(.LEVEL_W(4), .LINES_W(4)) bus ();

  game_flow_ctrl #(
    .LEVEL_W        (4),
    .MAX_LEVEL      (2),
    .LINES_PER_LEVEL(10),
    .LINES_W        (4),
    .OVER_HOLD      (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [2:0] n);
    bus.lines_vld = 1'b1;
    bus.lines_n   = n;
    step();
    bus.lines_vld = 1'b0;
    bus.lines_n   = 3'd0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.start_pulse = 1'b0;
    bus.pause_pulse = 1'b0;
    bus.game_over   = 1'b0;
    bus.lines_vld   = 1'b0;
    bus.lines_n     = 3'd0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("rst_ingame", 32'(bus.ingame_sig), 0);
    chk("rst_paused", 32'(bus.paused), 0);
    chk("rst_over", 32'(bus.over_sig), 0);
    chk("rst_newgame", 32'(bus.new_game), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_total", 32'(bus.lines_total), 0);

    // lines_vld and game_over in READY must do nothing
    bus.game_over = 1'b1;
    strobe(3'd4);
    bus.game_over = 1'b0;
    chk("ready_ign_total", 32'(bus.lines_total), 0);
    chk("ready_ign_over", 32'(bus.over_sig), 0);

    bus.start_pulse = 1'b1; step(); bus.start_pulse = 1'b0;
    chk("start_ingame", 32'(bus.ingame_sig), 1);
    chk("start_newgame", 32'(bus.new_game), 1);
    step();
    chk("newgame_once", 32'(bus.new_game), 0);
    chk("still_play", 32'(bus.ingame_sig), 1);

    bus.pause_pulse = 1'b1; step(); bus.pause_pulse = 1'b0;
    chk("pause_paused", 32'(bus.paused), 1);
    chk("pause_ingame", 32'(bus.ingame_sig), 0);
    bus.game_over = 1'b1;
    repeat (3) step();
    chk("pause_go_paused", 32'(bus.paused), 1);
    chk("pause_go_over", 32'(bus.over_sig), 0);
    bus.game_over = 1'b0;
    strobe(3'd4);
    chk("pause_ign_total", 32'(bus.lines_total), 0);
    bus.pause_pulse = 1'b1; step(); bus.pause_pulse = 1'b0;
    chk("resume_ingame", 32'(bus.ingame_sig), 1);
    chk("resume_paused", 32'(bus.paused), 0);
    chk("resume_no_newgame", 32'(bus.new_game), 0);

    strobe(3'd4);
    chk("l4_total", 32'(bus.lines_total), 4);
    chk("l4_level", 32'(bus.level), 0);
    strobe(3'd4);
    chk("l8_total", 32'(bus.lines_total), 8);
    strobe(3'd3);
    chk("l11_total", 32'(bus.lines_total), 11);
    chk("l11_level", 32'(bus.level), 1);

    // lines, game_over and pause in one cycle: lines count, OVER wins
    bus.lines_vld = 1'b1; bus.lines_n = 3'd2;
    bus.game_over = 1'b1; bus.pause_pulse = 1'b1;
    step();
    bus.lines_vld = 1'b0; bus.lines_n = 3'd0;
    bus.game_over = 1'b0; bus.pause_pulse = 1'b0;
    chk("sim_total", 32'(bus.lines_total), 13);
    chk("sim_over", 32'(bus.over_sig), 1);
    chk("sim_paused", 32'(bus.paused), 0);

    cnt = 1;
    strobe(3'd3);
    if (bus.over_sig) cnt++;
    for (int i = 0; i < 20 && bus.over_sig; i++) begin
      step();
      if (bus.over_sig) cnt++;
    end
    chk("over_len", 32'(cnt), 8);
    chk("over_ign_total", 32'(bus.lines_total), 13);
    chk("ready_ingame", 32'(bus.ingame_sig), 0);
    chk("ready_keep_level", 32'(bus.level), 1);
    chk("ready_keep_total", 32'(bus.lines_total), 13);

    bus.start_pulse = 1'b1; bus.pause_pulse = 1'b1; step();
    bus.start_pulse = 1'b0; bus.pause_pulse = 1'b0;
    chk("sp_ingame", 32'(bus.ingame_sig), 1);
    chk("sp_newgame", 32'(bus.new_game), 1);
    chk("sp_clr_total", 32'(bus.lines_total), 0);
    chk("sp_clr_level", 32'(bus.level), 0);

    strobe(3'd7);
    chk("clamp_total", 32'(bus.lines_total), 4);
    repeat (9) strobe(3'd4);
    chk("sat_total", 32'(bus.lines_total), 15);
    chk("sat_level", 32'(bus.level), 2);

    bus.game_over = 1'b1; step(); bus.game_over = 1'b0;
    chk("go2_over", 32'(bus.over_sig), 1);
    step();
    bus.start_pulse = 1'b1; step(); bus.start_pulse = 1'b0;
    chk("early_over", 32'(bus.over_sig), 0);
    chk("early_ingame", 32'(bus.ingame_sig), 0);
    chk("early_newgame", 32'(bus.new_game), 0);

    bus.start_pulse = 1'b1; step(); bus.start_pulse = 1'b0;
    strobe(3'd3);
    chk("g3_total", 32'(bus.lines_total), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ingame", 32'(bus.ingame_sig), 0);
    chk("mid_rst_total", 32'(bus.lines_total), 0);
    chk("mid_rst_level", 32'(bus.level), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_newgame", 32'(bus.new_game), 0);
    chk("post_rst_ingame", 32'(bus.ingame_sig), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
